// File: rtl/pipe_ctrl_gen.sv
// ============================================================================
//  Module      : pipe_ctrl_gen
//  Description : Stall/flush controller for an NSTAGE-deep in-order pipeline.
//                Deepest stall request wins, exceptions flush the whole pipe,
//                an exception-drain FSM discards an in-flight fetch, a stall
//                watchdog flags deadlock, and saturating perf counters track
//                stall cycles and accepted exceptions.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl_gen #(
  parameter int NSTAGE   = 5,
  parameter int DC_STAGE = 3,
  parameter int CNT_W    = 16,
  parameter int WD_LIMIT = 1023
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NSTAGE-1:0] streq_i,
  input  logic              exc_flag_i,
  input  logic              icache_stall_i,
  input  logic              dcache_stall_i,
  output logic [NSTAGE-1:0] stall_o,
  output logic [NSTAGE-1:0] flush_o,
  output logic              drain_o,
  output logic              deadlock_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  exc_cnt_o
);

  localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] C_WD_LIMIT = CNT_W'(WD_LIMIT);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LAST  = 2'd2
  } state_t;

  state_t             state_q;
  logic               drain_q;
  logic [CNT_W-1:0]   wd_q, wd_d;
  logic               deadlock_q, deadlock_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   exc_cnt_q, exc_cnt_d;

  logic [NSTAGE-1:0]  w_req;
  logic [NSTAGE-1:0]  w_s;
  logic               w_acc;

  // Resolve stall priority and build the same-cycle stall/flush vectors
  always_comb begin
    w_req           = streq_i;
    w_req[0]        = icache_stall_i;
    w_req[DC_STAGE] = streq_i[DC_STAGE] | dcache_stall_i;

    // A stage stalls when it or any deeper stage requests a stall
    w_acc = 1'b0;
    w_s   = '0;
    for (int j = NSTAGE - 1; j >= 0; j--) begin
      w_acc  = w_acc | w_req[j];
      w_s[j] = w_acc;
    end

    stall_o             = w_s;
    stall_o[NSTAGE-1]   = 1'b0;

    // Bubble goes into the first stage downstream of the held block
    flush_o    = '0;
    for (int j = 1; j < NSTAGE; j++) begin
      flush_o[j] = w_s[j-1] & ~w_s[j];
    end
    // PC redirect and the stale-fetch drain both kill the fetch stage output;
    // a simultaneous deeper stall is left visible so the stage can prioritise
    flush_o[1] = flush_o[1] | streq_i[0] | drain_q;

    drain_o = drain_q;

    if (exc_flag_i) begin
      stall_o = '0;
      flush_o = {{(NSTAGE-1){1'b1}}, 1'b0};
    end

    if (!resetn) begin
      stall_o = '0;
      flush_o = {{(NSTAGE-1){1'b1}}, 1'b0};
      drain_o = 1'b0;
    end
  end

  // Exception-drain FSM; drain_q is the registered "not RUN" indication
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= RUN;
      drain_q <= 1'b0;
    end else if (exc_flag_i && icache_stall_i) begin
      state_q <= DRAIN;
      drain_q <= 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          state_q <= RUN;
          drain_q <= 1'b0;
        end
        DRAIN: begin
          if (!icache_stall_i) begin
            state_q <= LAST;
          end
          drain_q <= 1'b1;
        end
        LAST: begin
          state_q <= RUN;
          drain_q <= 1'b0;
        end
        default: begin
          state_q <= RUN;
          drain_q <= 1'b0;
        end
      endcase
    end
  end

  // Next-state for watchdog and saturating performance counters
  always_comb begin
    if (stall_o[0]) begin
      wd_d = (wd_q == C_WD_LIMIT) ? wd_q : wd_q + CNT_W'(1);
    end else begin
      wd_d = '0;
    end
    deadlock_d = deadlock_q | (wd_d == C_WD_LIMIT);

    stall_cnt_d = stall_cnt_q;
    if ((|stall_o) && (stall_cnt_q != C_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    exc_cnt_d = exc_cnt_q;
    if (exc_flag_i && (exc_cnt_q != C_CNT_MAX)) begin
      exc_cnt_d = exc_cnt_q + CNT_W'(1);
    end
  end

  // Watchdog and counter registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wd_q        <= '0;
      deadlock_q  <= 1'b0;
      stall_cnt_q <= '0;
      exc_cnt_q   <= '0;
    end else begin
      wd_q        <= wd_d;
      deadlock_q  <= deadlock_d;
      stall_cnt_q <= stall_cnt_d;
      exc_cnt_q   <= exc_cnt_d;
    end
  end

  assign deadlock_o  = deadlock_q;
  assign stall_cnt_o = stall_cnt_q;
  assign exc_cnt_o   = exc_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl_gen.sv
// ============================================================================
//  Module      : tb_pipe_ctrl_gen
//  Description : Scoreboard bench for pipe_ctrl_gen (NSTAGE=5, DC_STAGE=3,
//                CNT_W=4, WD_LIMIT=8) with directed and random stimulus.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl_gen;

  localparam int N   = 5;
  localparam int DC  = 3;
  localparam int CW  = 4;
  localparam int WDL = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          resetn;
  logic [N-1:0]  streq;
  logic          exc, ic, dc;
  logic [N-1:0]  stall, flush;
  logic          drain, dead;
  logic [CW-1:0] scnt, ecnt;

  pipe_ctrl_gen #(.NSTAGE(N), .DC_STAGE(DC), .CNT_W(CW), .WD_LIMIT(WDL)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .streq_i        (streq),
    .exc_flag_i     (exc),
    .icache_stall_i (ic),
    .dcache_stall_i (dc),
    .stall_o        (stall),
    .flush_o        (flush),
    .drain_o        (drain),
    .deadlock_o     (dead),
    .stall_cnt_o    (scnt),
    .exc_cnt_o      (ecnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  stall;
    logic [N-1:0]  flush;
    logic          drain;
    logic          dead;
    logic [CW-1:0] scnt;
    logic [CW-1:0] ecnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference model state: mode 0 = normal, 1 = draining, 2 = final drain cycle
  int   m_mode, m_wd, m_sc, m_ec;
  bit   m_dead;

  task automatic model_reset();
    m_mode = 0; m_wd = 0; m_sc = 0; m_ec = 0; m_dead = 0;
  endtask

  // Drive one cycle of inputs, queue the expected response, advance the model
  task automatic step(input logic rn, input logic [N-1:0] sr,
                      input logic e, input logic i, input logic d);
    exp_t x;
    int   k;
    @(posedge clk);
    #1;
    resetn = rn; streq = sr; exc = e; ic = i; dc = d;

    k = -1;
    for (int j = 0; j < N; j++) begin
      if ((j == 0) ? i : (sr[j] || (j == DC && d))) k = j;
    end

    x = '0;
    if (!rn || e) begin
      x.stall = '0;
      x.flush = 5'b11110;
    end else begin
      if (k >= 0) x.stall = N'((1 << (k + 1)) - 1) & 5'b01111;
      if (k >= 0 && k + 1 < N) x.flush[k+1] = 1'b1;
      if (sr[0] || m_mode != 0) x.flush[1] = 1'b1;
    end
    x.drain = rn && (m_mode != 0);
    x.dead  = m_dead;
    x.scnt  = CW'(m_sc);
    x.ecnt  = CW'(m_ec);
    exp_q.push_back(x);

    if (!rn) begin
      model_reset();
    end else begin
      m_wd = x.stall[0] ? m_wd + 1 : 0;
      if (m_wd >= WDL) m_dead = 1;
      if (x.stall != 0 && m_sc < CMAX) m_sc++;
      if (e && m_ec < CMAX) m_ec++;
      if (e && i) m_mode = 1;
      else if (m_mode == 1) m_mode = i ? 1 : 2;
      else m_mode = 0;
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  // Monitor: outputs are valid every cycle, compare at the falling edge
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("stall_o",     int'(stall), int'(x.stall));
        chk("flush_o",     int'(flush), int'(x.flush));
        chk("drain_o",     int'(drain), int'(x.drain));
        chk("deadlock_o",  int'(dead),  int'(x.dead));
        chk("stall_cnt_o", int'(scnt),  int'(x.scnt));
        chk("exc_cnt_o",   int'(ecnt),  int'(x.ecnt));
      end
    end
  end

  initial begin
    resetn = 1'b0; streq = '0; exc = 1'b0; ic = 1'b0; dc = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state
    step(0, 5'b00000, 0, 0, 0);
    step(1, 5'b00000, 0, 0, 0);

    // Priority resolution
    step(1, 5'b01000, 0, 0, 0);
    step(1, 5'b00000, 0, 0, 1);
    step(1, 5'b10000, 0, 0, 0);
    step(1, 5'b00000, 0, 1, 0);
    step(1, 5'b00001, 0, 0, 0);
    step(1, 5'b00101, 0, 0, 0);
    step(1, 5'b00110, 0, 1, 1);

    // Exception overrides stall requests
    step(1, 5'b00100, 1, 0, 0);
    step(1, 5'b00000, 0, 0, 0);

    // Exception while a fetch is outstanding: drain sequence
    step(1, 5'b00000, 1, 1, 0);
    repeat (3) step(1, 5'b00000, 0, 1, 0);
    repeat (3) step(1, 5'b00000, 0, 0, 0);

    // Watchdog: two 7-cycle stalls with a gap must not trip it
    repeat (7) step(1, 5'b00000, 0, 1, 0);
    step(1, 5'b00000, 0, 0, 0);
    repeat (7) step(1, 5'b00000, 0, 1, 0);
    repeat (2) step(1, 5'b00000, 0, 0, 0);
    // Watchdog: 8 stalled cycles sets a sticky deadlock flag
    repeat (8) step(1, 5'b00000, 0, 1, 0);
    repeat (3) step(1, 5'b00000, 0, 0, 0);

    // Stall counter saturation, then reset in the middle of a drain
    step(0, 5'b00000, 0, 0, 0);
    repeat (20) step(1, 5'b00010, 0, 0, 0);
    step(1, 5'b00000, 1, 1, 0);
    step(1, 5'b00000, 0, 1, 0);
    step(0, 5'b00000, 0, 1, 0);
    repeat (2) step(1, 5'b00000, 0, 0, 0);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) != 0),
           N'($urandom) & N'($urandom) & N'($urandom),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 9) < 2));
    end

    for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_queue left=%0d want=0", exp_q.size());
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_ctrl_gen.md
Name: pipe_ctrl_gen

Overview:
Parametrised stall/flush controller for an NSTAGE-deep in-order pipeline. Stage 0 is PC/fetch and stage NSTAGE-1 is writeback. Stall requests are resolved by priority: the deepest requesting stage wins. Exceptions flush the whole pipe. Adds an exception-drain FSM that discards a fetch still in flight at exception time, a stall watchdog, and saturating performance counters.

Parameters:
NSTAGE, 5, number of pipeline stages (≥3); index 0 = PC, index NSTAGE-1 = WB
DC_STAGE, 3, stage index at which dcache_stall_i is merged as a stall request (1..NSTAGE-2)
CNT_W, 16, width of performance counters
WD_LIMIT, 1023, consecutive stall_o[0] cycles before deadlock_o sets (1..2^CNT_W-1)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
streq_i  in  NSTAGE  per-stage stall request; bit 0 (PC request) does not stall, it forces flush_o[1]
exc_flag_i  in  1  exception/eret commit, single-cycle pulse
icache_stall_i  in  1  icache miss in progress
dcache_stall_i  in  1  dcache/AXI busy
stall_o  out  NSTAGE  stage hold enables
flush_o  out  NSTAGE  stage bubble-insert enables; bit 0 is always 0
drain_o  out  1  high while in DRAIN state
deadlock_o  out  1  sticky watchdog flag
stall_cnt_o  out  CNT_W  cycles with any stall_o bit set, saturating
exc_cnt_o  out  CNT_W  accepted exceptions, saturating

Behaviour:
- Raw request vector: r[k] = streq_i[k] for k ≥ 1, r[DC_STAGE] |= dcache_stall_i, r[0] = icache_stall_i.
- Priority: let K = the highest k with r[k] = 1. Then s[j] = 1 for all j ≤ K; if no request, s = 0.
- stall_o[j] = s[j] for j < NSTAGE-1. stall_o[NSTAGE-1] is always 0.
- Base flush: flush_o[j] = s[j-1] & ~s[j] for j ≥ 1. flush_o[1] is additionally ORed with streq_i[0].
- Exception cycle (exc_flag_i = 1):
  - stall_o = 0.
  - flush_o[j] = 1 for all j ≥ 1.
  - Exception overrides all stall requests, including icache and dcache.
- stall_o and flush_o are purely combinational, same-cycle, except for the FSM term below.
- FSM states:
  - RUN: if exc_flag_i & icache_stall_i, go to DRAIN.
  - DRAIN: while icache_stall_i = 1, stay. When icache_stall_i = 0, go to LAST.
  - LAST: go to RUN next cycle.
  - exc_flag_i & icache_stall_i in any state re-enters DRAIN.
- In DRAIN and LAST, flush_o[1] is forced to 1 so the stale fetch response is discarded. All other bits follow normal rules. drain_o = 1 in DRAIN and LAST.
- Watchdog:
  - wd counter increments each cycle stall_o[0] = 1 and clears when stall_o[0] = 0.
  - When wd = WD_LIMIT, deadlock_o is set.
  - deadlock_o is sticky until reset and does not saturate-wrap.
- stall_cnt_o increments on any cycle with |stall_o = 1. exc_cnt_o increments on exc_flag_i. Both stop at all-ones.
- Reset (resetn = 0 at a clk edge):
  - State goes to RUN; wd, counters and deadlock_o clear to 0.
  - While resetn is low, outputs are combinationally forced: stall_o = 0, flush_o[NSTAGE-1:1] all 1, drain_o = 0.
  - Reset mid-DRAIN returns to RUN with no residual flush.
- Simultaneous events:
  - exc_flag_i with any streq: exception wins.
  - streq_i[0] with a deeper stall: flush_o[1] = 1 and stall_o[1] = 1 both assert. The stage must give stall priority; this is documented, not masked.

Test Plan:
- NSTAGE=5, streq_i = 5'b01000 (stage 3) -> stall_o = 5'b01111, flush_o = 5'b10000; with dcache_stall_i = 1 alone -> same vectors.
- streq_i = 5'b10000 (WB request) -> stall_o = 5'b01111, flush_o = 0. Then icache_stall_i only -> stall_o = 5'b00001, flush_o = 5'b00010.
- Pulse exc_flag_i with streq_i = 5'b00100 -> stall_o = 0, flush_o = 5'b11110 that cycle, exc_cnt_o = 1 next cycle.
- exc_flag_i while icache_stall_i = 1, icache_stall_i held 3 more cycles -> drain_o high for 5 cycles total; flush_o[1] = 1 each of those cycles; state back to RUN after LAST.
- WD_LIMIT = 8, icache_stall_i held 8 cycles -> deadlock_o rises after the 8th edge and stays high when the stall drops. A 7-cycle stall, a gap, then a 7-cycle stall -> deadlock_o stays 0.
- CNT_W = 4, continuous stall for 20 cycles -> stall_cnt_o = 4'hF. Assert resetn = 0 during DRAIN -> next cycle all counters 0, drain_o = 0, flush_o follows the reset force rule.
